aes_masked_seq_ctrl: RTL and testbench

Parametrised sequencing controller for the masked AES encryption datapath. It is the next generation of the fixed AES-128, one-cycle-per-round control.
- Supports AES-128/192/256 round counts, selected per job.
- Cycles-per-round is configurable, for narrower S-box arrays.
- Handles key destruction with a timed wipe phase.
- Drives the register, coding, share-restore and unmask phase strobes of the masked core and the task handshake with the host wrapper.

---
 rtl/aes_masked_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_aes_masked_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_masked_seq_ctrl.sv
// Sequencing controller for the masked AES encryption datapath: round/cycle counting,
// phase strobes, timed key wipe. Optional dummy rounds via `define FIQ_DUMMY_ROUND_EN.
module aes_masked_seq_ctrl #(
  parameter int CPR      = 1,
  parameter int WIPE_CYC = 4,
  parameter int DUMMY_W  = 2
) (
  input  logic                                 clk_i,
  input  logic                                 arst_n_i,
  input  logic                                 start_i,
  input  logic [1:0]                           keylen_i,
  input  logic                                 key_destruct_i,
  input  logic [DUMMY_W-1:0]                   rand_i,
  output logic                                 ready_o,
  output logic                                 ctrl_st_load_o,
  output logic                                 ctrl_st_entry_o,
  output logic                                 ctrl_st_code_o,
  output logic                                 ctrl_round_first_o,
  output logic                                 ctrl_last_o,
  output logic                                 ctrl_st_dummy_o,
  output logic                                 ctrl_st_out_o,
  output logic                                 ctrl_st_unmask_o,
  output logic                                 ctrl_key_wipe_o,
  output logic [3:0]                           round_o,
  output logic [((CPR > 1) ? $clog2(CPR) : 1)-1:0] cyc_o,
  output logic                                 done_o,
  output logic                                 err_o,
  output logic [2:0]                           dbg_state_o
);

  localparam int CYC_W = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CPR - 1);
  localparam logic [7:0]       WIPE_LAST = 8'(WIPE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_DUMMY, ST_CODE, ST_OUT, ST_UNMASK, ST_WIPE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       nr_q;
  logic [3:0]       round_q;
  logic [CYC_W-1:0] cyc_q;
  logic [7:0]       wipe_cnt_q;
  logic             err_q;
  logic             cyc_wrap;
  logic             counting_q, counting_d;
  logic             dummy_req, dummy_last;

  assign cyc_wrap   = (cyc_q == CYC_LAST);
  assign counting_q = (state_q == ST_DUMMY) || (state_q == ST_CODE);
  assign counting_d = (state_d == ST_DUMMY) || (state_d == ST_CODE);

`ifdef FIQ_DUMMY_ROUND_EN
  logic [DUMMY_W-1:0] dummy_q;

  assign dummy_req  = (rand_i != '0);
  assign dummy_last = (dummy_q == DUMMY_W'(1));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      dummy_q <= '0;
    end else if (state_d == ST_WIPE) begin
      dummy_q <= '0;
    end else if (state_q == ST_LOAD) begin
      dummy_q <= rand_i;
    end else if (state_q == ST_DUMMY && cyc_wrap) begin
      dummy_q <= dummy_q - 1'b1;
    end
  end
`else
  logic unused_rand;

  assign unused_rand = ^rand_i;
  assign dummy_req   = 1'b0;
  assign dummy_last  = 1'b1;
`endif

  // Destruct overrides every state, including a start arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (key_destruct_i) begin
      state_d = ST_WIPE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_i && keylen_i != 2'd3) state_d = ST_LOAD;
        ST_LOAD:   state_d = dummy_req ? ST_DUMMY : ST_CODE;
        ST_DUMMY:  if (cyc_wrap && dummy_last) state_d = ST_CODE;
        ST_CODE:   if (cyc_wrap && round_q == nr_q) state_d = ST_OUT;
        ST_OUT:    state_d = ST_UNMASK;
        ST_UNMASK: state_d = ST_IDLE;
        ST_WIPE:   if (wipe_cnt_q == WIPE_LAST) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      nr_q       <= '0;
      round_q    <= '0;
      cyc_q      <= '0;
      wipe_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= (state_q == ST_IDLE) && start_i && (keylen_i == 2'd3) && !key_destruct_i;
      wipe_cnt_q <= (state_d == ST_WIPE && !key_destruct_i) ? wipe_cnt_q + 1'b1 : '0;
      if (state_d == ST_LOAD) nr_q <= 4'd10 + {1'b0, keylen_i, 1'b0};
      cyc_q <= (counting_q && counting_d && !cyc_wrap) ? cyc_q + 1'b1 : '0;
      // Round index is only meaningful in CODE; dummy rounds report round 0.
      if (state_d == ST_CODE) begin
        if (state_q != ST_CODE)  round_q <= 4'd1;
        else if (cyc_wrap)       round_q <= round_q + 1'b1;
      end else begin
        round_q <= '0;
      end
    end
  end

  assign ready_o            = (state_q == ST_IDLE);
  assign ctrl_st_load_o     = (state_q == ST_LOAD);
  assign ctrl_st_dummy_o    = (state_q == ST_DUMMY);
  assign ctrl_st_code_o     = (state_q == ST_CODE);
  assign ctrl_st_entry_o    = ctrl_st_code_o && (round_q == 4'd1) && (cyc_q == '0);
  assign ctrl_round_first_o = ctrl_st_code_o && (cyc_q == '0);
  assign ctrl_last_o        = ctrl_st_code_o && (round_q == nr_q);
  assign ctrl_st_out_o      = (state_q == ST_OUT);
  assign ctrl_st_unmask_o   = (state_q == ST_UNMASK);
  assign ctrl_key_wipe_o    = (state_q == ST_WIPE);
  assign done_o             = (state_q == ST_UNMASK);
  assign err_o              = err_q;
  assign round_o            = round_q;
  assign cyc_o              = cyc_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_aes_masked_seq_ctrl.sv
// Self-checking bench for aes_masked_seq_ctrl: per-cycle output traces built from the
// job timing rules, compared against the DUT while random noise is applied to idle inputs.
module tb_aes_masked_seq_ctrl;

  localparam int CPR      = 2;
  localparam int WIPE_CYC = 4;
  localparam int DUMMY_W  = 2;
  localparam int CYC_W    = (CPR > 1) ? $clog2(CPR) : 1;
  localparam int W        = 16 + CYC_W;

  logic               clk_i = 1'b0;
  logic               arst_n_i;
  logic               start_i;
  logic [1:0]         keylen_i;
  logic               key_destruct_i;
  logic [DUMMY_W-1:0] rand_i;
  logic               ready_o, ctrl_st_load_o, ctrl_st_entry_o, ctrl_st_code_o;
  logic               ctrl_round_first_o, ctrl_last_o, ctrl_st_dummy_o, ctrl_st_out_o;
  logic               ctrl_st_unmask_o, ctrl_key_wipe_o, done_o, err_o;
  logic [3:0]         round_o;
  logic [CYC_W-1:0]   cyc_o;
  logic [2:0]         dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dut_vec;

  aes_masked_seq_ctrl #(.CPR(CPR), .WIPE_CYC(WIPE_CYC), .DUMMY_W(DUMMY_W)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .start_i(start_i), .keylen_i(keylen_i),
    .key_destruct_i(key_destruct_i), .rand_i(rand_i), .ready_o(ready_o),
    .ctrl_st_load_o(ctrl_st_load_o), .ctrl_st_entry_o(ctrl_st_entry_o),
    .ctrl_st_code_o(ctrl_st_code_o), .ctrl_round_first_o(ctrl_round_first_o),
    .ctrl_last_o(ctrl_last_o), .ctrl_st_dummy_o(ctrl_st_dummy_o),
    .ctrl_st_out_o(ctrl_st_out_o), .ctrl_st_unmask_o(ctrl_st_unmask_o),
    .ctrl_key_wipe_o(ctrl_key_wipe_o), .round_o(round_o), .cyc_o(cyc_o),
    .done_o(done_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  assign dut_vec = {ready_o, ctrl_st_load_o, ctrl_st_entry_o, ctrl_st_code_o,
                    ctrl_round_first_o, ctrl_last_o, ctrl_st_dummy_o, ctrl_st_out_o,
                    ctrl_st_unmask_o, ctrl_key_wipe_o, done_o, err_o, round_o, cyc_o};

  function automatic logic [W-1:0] mk(input logic ready, load, entry, code, rfirst, last,
                                      dummy, outp, unmask, wipe, done, err,
                                      input int rnd, input int cyc);
    logic [3:0]       r4;
    logic [CYC_W-1:0] cw;
    r4 = 4'(rnd);
    cw = CYC_W'(cyc);
    return {ready, load, entry, code, rfirst, last, dummy, outp, unmask, wipe, done, err, r4, cw};
  endfunction

  function automatic int eff_dummies(input int d);
`ifdef FIQ_DUMMY_ROUND_EN
    return d;
`else
    return 0;
`endif
  endfunction

  // One whole job: load, D dummy rounds, Nr coding rounds, out, unmask/done.
  task automatic push_job(input int k, input int d);
    int nr;
    nr = 10 + 2 * k;
    exp_q.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0, 0, 0));
    for (int i = 0; i < d * CPR; i++)
      exp_q.push_back(mk(0,0,0,0,0,0,1,0,0,0,0,0, 0, i % CPR));
    for (int i = 0; i < nr * CPR; i++) begin
      int r, c;
      r = i / CPR + 1;
      c = i % CPR;
      exp_q.push_back(mk(0,0,(i == 0),1,(c == 0),(r == nr),0,0,0,0,0,0, r, c));
    end
    exp_q.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,0, 0, 0));
    exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,0,1,0, 0, 0));
  endtask

  task automatic push_wipe(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0, 0, 0));
  endtask

  task automatic push_idle();
    exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0, 0));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input int k, input int d);
    start_i  = 1'b1;
    keylen_i = 2'(k);
    rand_i   = DUMMY_W'(d);
    step();
    start_i  = 1'b0;
  endtask

  // Walks the expected queue one cycle at a time; noise on start/keylen must be ignored.
  task automatic run_trace(input string name, input int destruct_at, output int done_idx);
    int n;
    logic [W-1:0] e;
    n = exp_q.size();
    done_idx = -1;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, dut_vec, e);
      end
      if (done_o === 1'b1 && done_idx < 0) done_idx = i;
      if (i < n - 1) begin
        start_i        = 1'($urandom_range(0, 1));
        keylen_i       = 2'($urandom_range(0, 3));
        key_destruct_i = (i == destruct_at);
        step();
        key_destruct_i = 1'b0;
        if (i == 0) rand_i = DUMMY_W'($urandom);
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    arst_n_i = 1'b0;
    #1;
    checks++;
    if (dut_vec !== mk(1,0,0,0,0,0,0,0,0,0,0,0, 0, 0)) begin
      errors++;
      $display("FAIL reset_value: got %h expected %h", dut_vec, mk(1,0,0,0,0,0,0,0,0,0,0,0, 0, 0));
    end
    step();
    step();
    arst_n_i = 1'b1;
    step();
  endtask

  task automatic run_job(input string name, input int k, input int d);
    int di, de;
    de = eff_dummies(d);
    start_job(k, d);
    push_job(k, de);
    push_idle();
    run_trace(name, -1, di);
    checks++;
    if (di != de * CPR + (10 + 2 * k) * CPR + 2) begin
      errors++;
      $display("FAIL %s_latency: done index %0d expected %0d", name, di,
               de * CPR + (10 + 2 * k) * CPR + 2);
    end
  endtask

  task automatic test_keylens();
    run_job("aes128_nodummy", 0, 0);
    run_job("aes256_nodummy", 2, 0);
    run_job("aes128_dummy3", 0, 3);
    for (int j = 0; j < 5; j++) run_job("random_job", $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  task automatic test_illegal_keylen();
    int di;
    start_i  = 1'b1;
    keylen_i = 2'd3;
    step();
    start_i  = 1'b0;
    exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,1, 0, 0));
    exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0, 0));
    keylen_i = 2'd0;
    checks++;
    if (dut_vec !== exp_q[0]) begin
      errors++;
      $display("FAIL illegal_err_pulse: got %h expected %h", dut_vec, exp_q[0]);
    end
    void'(exp_q.pop_front());
    step();
    run_trace("illegal_after", -1, di);
  endtask

  task automatic test_destruct_mid_job();
    int di, at, d;
    d  = eff_dummies($urandom_range(0, 3));
    start_job(0, d);
    push_job(0, d);
    at = 1 + d * CPR + 4 * CPR + $urandom_range(0, CPR - 1);
    while (exp_q.size() > at + 1) void'(exp_q.pop_back());
    push_wipe(WIPE_CYC);
    push_idle();
    run_trace("destruct_round5", at, di);
    checks++;
    if (di != -1) begin
      errors++;
      $display("FAIL destruct_no_done: done seen at %0d expected none", di);
    end
  endtask

  task automatic test_wipe_restart();
    int di;
    start_i        = 1'b1;
    keylen_i       = 2'd1;
    key_destruct_i = 1'b1;
    step();
    start_i        = 1'b0;
    key_destruct_i = 1'b0;
    push_wipe(3 + WIPE_CYC);
    push_idle();
    run_trace("destruct_start_restart", 2, di);
    run_job("after_wipe", 1, 0);
  endtask

  task automatic test_async_reset();
    start_job(1, 0);
    for (int i = 0; i < 9; i++) step();
    #3;
    arst_n_i = 1'b0;
    #1;
    checks++;
    if (dut_vec !== mk(1,0,0,0,0,0,0,0,0,0,0,0, 0, 0)) begin
      errors++;
      $display("FAIL async_reset_midcode: got %h expected %h", dut_vec, mk(1,0,0,0,0,0,0,0,0,0,0,0, 0, 0));
    end
    step();
    arst_n_i = 1'b1;
    step();
    run_job("post_reset_job", 2, 1);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) run_job("back_to_back", j, $urandom_range(0, 3));
  endtask

  initial begin
    start_i        = 1'b0;
    keylen_i       = 2'd0;
    key_destruct_i = 1'b0;
    rand_i         = '0;
    test_reset();
    test_keylens();
    test_illegal_keylen();
    test_destruct_mid_job();
    test_wipe_restart();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
